// File: rtl/axi4_burst_controller.sv
// axi4_burst_controller
// Moves one cache line per request as a single AXI4 INCR burst of BEATS beats,
// either as a write-back (AW/W/B) or a refill (AR/R). Reports SLVERR/DECERR
// responses and R-channel last-beat mismatches through o_axi_err alongside a
// one-cycle o_axi_ack completion pulse.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_start_read / i_start_write : request strobes, sampled only in IDLE
//   i_req_addr                   : line address (low offset bits ignored)
//   i_wline / o_rline            : write-back / refill line, beat 0 at LSBs
//   o_axi_ack, o_axi_err         : completion pulse and error flag
//   AW/W/B, AR/R                 : AXI4 master channels (size/burst tied off outside)
//
// Build option: define AXI4_BURST_OVERLAP_EN to issue AW and W concurrently.
module axi4_burst_controller #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start_read,
    input  logic                    i_start_write,
    input  logic [ADDR_W-1:0]       i_req_addr,
    input  logic [BEATS*DATA_W-1:0] i_wline,
    output logic [BEATS*DATA_W-1:0] o_rline,
    output logic                    o_axi_ack,
    output logic                    o_axi_err,
    output logic                    o_aw_valid,
    input  logic                    i_aw_ready,
    output logic [ADDR_W-1:0]       o_aw_addr,
    output logic [7:0]              o_aw_len,
    output logic                    o_w_valid,
    input  logic                    i_w_ready,
    output logic [DATA_W-1:0]       o_w_data,
    output logic                    o_w_last,
    input  logic                    i_b_valid,
    output logic                    o_b_ready,
    input  logic [1:0]              i_b_resp,
    output logic                    o_ar_valid,
    input  logic                    i_ar_ready,
    output logic [ADDR_W-1:0]       o_ar_addr,
    output logic [7:0]              o_ar_len,
    input  logic                    i_r_valid,
    output logic                    o_r_ready,
    input  logic [DATA_W-1:0]       i_r_data,
    input  logic [1:0]              i_r_resp,
    input  logic                    i_r_last
);

    localparam int unsigned LINE_W = BEATS * DATA_W;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(BEATS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_BRESP, S_RADDR, S_RDATA
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_err, w_err_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [LINE_W-1:0]   r_wline, w_wline_nxt;
    logic [LINE_W-1:0]   r_rline, w_rline_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_axi_err, w_axi_err_nxt;
    logic                r_aw_valid, w_aw_valid_nxt;
    logic                r_w_valid, w_w_valid_nxt;
    logic [DATA_W-1:0]   r_w_data, w_w_data_nxt;
    logic                r_w_last, w_w_last_nxt;
    logic                r_b_ready, r_ar_valid, r_r_ready;
`ifdef AXI4_BURST_OVERLAP_EN
    logic                r_aw_done, w_aw_done_nxt;
    logic                r_w_done, w_w_done_nxt;
`endif

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_cnt_last, w_b_err, w_r_err;

    assign w_aw_hs = r_aw_valid & i_aw_ready;
    assign w_w_hs  = r_w_valid  & i_w_ready;
    assign w_b_hs  = r_b_ready  & i_b_valid;
    assign w_ar_hs = r_ar_valid & i_ar_ready;
    assign w_r_hs  = r_r_ready  & i_r_valid;

    // Beat counter wraps to zero on the final beat (no-op when BEATS == 1).
    assign w_cnt_last = (r_cnt == LAST_BEAT);
    assign w_cnt_inc  = w_cnt_last ? '0 : CNT_W'(r_cnt + 1'b1);

    assign w_b_err = (i_b_resp == 2'b10) || (i_b_resp == 2'b11);
    // R beat is in error on SLVERR/DECERR or when r_last disagrees with the beat count.
    assign w_r_err = (i_r_resp == 2'b10) || (i_r_resp == 2'b11) || (i_r_last != w_cnt_last);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_err_nxt     = r_err;
        w_addr_nxt    = r_addr;
        w_wline_nxt   = r_wline;
        w_rline_nxt   = r_rline;
        w_ack_nxt     = 1'b0;
        w_axi_err_nxt = 1'b0;
`ifdef AXI4_BURST_OVERLAP_EN
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start_read) begin
                    w_addr_nxt  = i_req_addr & ADDR_MASK;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RADDR;
                end else if (i_start_write) begin
                    w_addr_nxt  = i_req_addr & ADDR_MASK;
                    w_wline_nxt = i_wline;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WADDR;
`ifdef AXI4_BURST_OVERLAP_EN
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
`endif
                end
            end
            S_WADDR: begin
`ifdef AXI4_BURST_OVERLAP_EN
                // AW and W run side by side; each done flag retires its channel.
                if (w_aw_hs) w_aw_done_nxt = 1'b1;
                if (w_w_hs) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_last) w_w_done_nxt = 1'b1;
                end
                if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = S_BRESP;
`else
                if (w_aw_hs) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WDATA;
                end
`endif
            end
            S_WDATA: begin
                if (w_w_hs) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_last) w_state_nxt = S_BRESP;
                end
            end
            S_BRESP: begin
                if (w_b_hs) begin
                    w_ack_nxt     = 1'b1;
                    w_axi_err_nxt = r_err | w_b_err;
                    w_err_nxt     = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_RADDR: begin
                if (w_ar_hs) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_r_hs) begin
                    w_rline_nxt[int'(r_cnt) * DATA_W +: DATA_W] = i_r_data;
                    w_cnt_nxt = w_cnt_inc;
                    w_err_nxt = r_err | w_r_err;
                    // Read always ends after BEATS beats, whatever r_last says.
                    if (w_cnt_last) begin
                        w_ack_nxt     = 1'b1;
                        w_axi_err_nxt = r_err | w_r_err;
                        w_err_nxt     = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef AXI4_BURST_OVERLAP_EN
        w_aw_valid_nxt = (w_state_nxt == S_WADDR) && !w_aw_done_nxt;
        w_w_valid_nxt  = (w_state_nxt == S_WADDR) && !w_w_done_nxt;
`else
        w_aw_valid_nxt = (w_state_nxt == S_WADDR);
        w_w_valid_nxt  = (w_state_nxt == S_WDATA);
`endif
        w_w_data_nxt = w_wline_nxt[int'(w_cnt_nxt) * DATA_W +: DATA_W];
        w_w_last_nxt = w_w_valid_nxt && (w_cnt_nxt == LAST_BEAT);
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wline    <= '0;
            r_rline    <= '0;
            r_ack      <= 1'b0;
            r_axi_err  <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_w_data   <= '0;
            r_w_last   <= 1'b0;
            r_b_ready  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
`ifdef AXI4_BURST_OVERLAP_EN
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_addr     <= w_addr_nxt;
            r_wline    <= w_wline_nxt;
            r_rline    <= w_rline_nxt;
            r_ack      <= w_ack_nxt;
            r_axi_err  <= w_axi_err_nxt;
            r_aw_valid <= w_aw_valid_nxt;
            r_w_valid  <= w_w_valid_nxt;
            r_w_data   <= w_w_data_nxt;
            r_w_last   <= w_w_last_nxt;
            r_b_ready  <= (w_state_nxt == S_BRESP);
            r_ar_valid <= (w_state_nxt == S_RADDR);
            r_r_ready  <= (w_state_nxt == S_RDATA);
`ifdef AXI4_BURST_OVERLAP_EN
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
`endif
        end
    end

    assign o_rline    = r_rline;
    assign o_axi_ack  = r_ack;
    assign o_axi_err  = r_axi_err;
    assign o_aw_valid = r_aw_valid;
    assign o_aw_addr  = r_addr;
    assign o_aw_len   = 8'(BEATS - 1);
    assign o_w_valid  = r_w_valid;
    assign o_w_data   = r_w_data;
    assign o_w_last   = r_w_last;
    assign o_b_ready  = r_b_ready;
    assign o_ar_valid = r_ar_valid;
    assign o_ar_addr  = r_addr;
    assign o_ar_len   = 8'(BEATS - 1);
    assign o_r_ready  = r_r_ready;

endmodule

// File: tb/tb_axi4_burst_controller.sv
// Self-checking bench for axi4_burst_controller (ADDR_W=32, DATA_W=32, BEATS=4).
// Acts as the AXI slave with directed and randomized stalls; expected values
// come from a line-level model: masked address, beat slices, error rules.
module tb_axi4_burst_controller;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEATS  = 4;
    localparam int unsigned LINE_W = BEATS * DATA_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS * DATA_W / 8 - 1);
`ifdef AXI4_BURST_OVERLAP_EN
    localparam int unsigned W_ACK_CYC = BEATS + 2;
`else
    localparam int unsigned W_ACK_CYC = BEATS + 3;
`endif
    localparam int unsigned R_ACK_CYC = BEATS + 2;

    logic              clk, reset;
    logic              start_read, start_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] wline, rline;
    logic              axi_ack, axi_err;
    logic              aw_valid, aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic              w_valid, w_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              b_valid, b_ready;
    logic [1:0]        b_resp;
    logic              ar_valid, ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              r_valid, r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [LINE_W-1:0] last_rline;
    int cyc;

    axi4_burst_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_start_read(start_read), .i_start_write(start_write),
        .i_req_addr(req_addr), .i_wline(wline), .o_rline(rline),
        .o_axi_ack(axi_ack), .o_axi_err(axi_err),
        .o_aw_valid(aw_valid), .i_aw_ready(aw_ready), .o_aw_addr(aw_addr), .o_aw_len(aw_len),
        .o_w_valid(w_valid), .i_w_ready(w_ready), .o_w_data(w_data), .o_w_last(w_last),
        .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_resp(b_resp),
        .o_ar_valid(ar_valid), .i_ar_ready(ar_ready), .o_ar_addr(ar_addr), .o_ar_len(ar_len),
        .i_r_valid(r_valid), .o_r_ready(r_ready), .i_r_data(r_data), .i_r_resp(r_resp),
        .i_r_last(r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < int'(BEATS); i++) v[i*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic clear_drives();
        start_read = 1'b0; start_write = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        ar_ready = 1'b0; r_valid = 1'b0; r_resp = 2'b00; r_last = 1'b0; r_data = '0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_ack", axi_ack, 1'b0);
        check("idle_hs", {aw_valid, w_valid, b_ready, ar_valid, r_ready}, 5'b0);
        check("idle_rline", rline, last_rline);
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                            input logic [1:0] bresp, input int unsigned stall,
                            input int unsigned aw_hold, input bit noise);
        int unsigned k = 0, c = 0, aw_cyc = 0, hold = aw_hold;
        bit aw_seen = 1'b0, done = 1'b0;
        start_write = 1'b1; req_addr = addr; wline = line;
        @(negedge clk);
        start_write = 1'b0; req_addr = $urandom; wline = rand_line();
        while (!done && c < 300) begin
            c++;
            check("w_ack_early", axi_ack, 1'b0);
            check("w_no_read", {ar_valid, r_ready}, 2'b00);
`ifndef AXI4_BURST_OVERLAP_EN
            check("w_order", w_valid & ~aw_seen, 1'b0);
`endif
            if (noise) begin
                start_read = 1'($urandom_range(1)); start_write = 1'($urandom_range(1));
            end
            if (aw_valid) aw_cyc++;
            if (hold > 0) begin aw_ready = 1'b0; hold--; end
            else aw_ready = ($urandom_range(99) >= stall);
            w_ready = ($urandom_range(99) >= stall);
            b_valid = b_ready && ($urandom_range(99) >= stall);
            b_resp  = b_valid ? bresp : 2'($urandom_range(3));
            if (aw_valid && aw_ready) begin
                check("aw_addr", aw_addr, addr & LINE_MASK);
                check("aw_len", aw_len, 8'(BEATS - 1));
                aw_seen = 1'b1;
            end
            if (w_valid && w_ready) begin
                check("w_data", w_data, (k < BEATS) ? line[k*DATA_W +: DATA_W] : '0);
                check("w_last", w_last, k == BEATS - 1);
                k++;
            end
            if (b_valid) begin
                check("b_after_all", {aw_seen, k == BEATS}, 2'b11);
                done = 1'b1;
            end
            @(negedge clk);
        end
        clear_drives();
        check("w_done", done, 1'b1);
        check("w_ack", axi_ack, 1'b1);
        check("w_err", axi_err, bresp[1]);
        if (stall == 0) begin
            check("aw_valid_cycles", aw_cyc, aw_hold + 1);
            if (aw_hold == 0) check("w_ack_cycle", c + 1, W_ACK_CYC);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                           input int resp_beat, input int last_bad, input int unsigned stall,
                           input bit alt_gap, input bit with_write, input bit noise);
        int unsigned k = 0, c = 0;
        bit ar_seen = 1'b0, done = 1'b0, phase = 1'b0;
        logic exp_err;
        exp_err = (resp_beat >= 0) || (last_bad >= 0);
        start_read = 1'b1; start_write = with_write; req_addr = addr; wline = rand_line();
        @(negedge clk);
        start_read = 1'b0; start_write = 1'b0; req_addr = $urandom;
        check("rline_hold", rline, last_rline);
        while (!done && c < 300) begin
            c++;
            check("r_ack_early", axi_ack, 1'b0);
            check("r_no_write", {aw_valid, w_valid, b_ready}, 3'b000);
            if (!ar_seen) check("r_ready_early", r_ready, 1'b0);
            if (noise) begin
                start_read = 1'($urandom_range(1)); start_write = 1'($urandom_range(1));
            end
            ar_ready = ($urandom_range(99) >= stall);
            if (ar_seen) begin
                phase   = ~phase;
                r_valid = alt_gap ? phase : ($urandom_range(99) >= stall);
            end else begin
                r_valid = 1'b0;
            end
            r_data = (k < BEATS) ? line[k*DATA_W +: DATA_W] : DATA_W'($urandom);
            r_resp = (int'(k) == resp_beat) ? 2'b10 : 2'($urandom_range(1));
            r_last = (k == BEATS - 1) ^ (int'(k) == last_bad);
            if (ar_valid && ar_ready) begin
                check("ar_addr", ar_addr, addr & LINE_MASK);
                check("ar_len", ar_len, 8'(BEATS - 1));
                ar_seen = 1'b1;
            end
            if (r_valid && r_ready) begin
                k++;
                if (k == BEATS) done = 1'b1;
            end
            @(negedge clk);
        end
        clear_drives();
        check("r_done", done, 1'b1);
        check("r_ack", axi_ack, 1'b1);
        check("r_err", axi_err, exp_err);
        check("r_ready_ack", r_ready, 1'b0);
        check("rline", rline, line);
        if (stall == 0 && !alt_gap) check("r_ack_cycle", c + 1, R_ACK_CYC);
        last_rline = line;
    endtask

    initial begin
        int unsigned st;
        int rb, lb;
        clear_drives();
        req_addr = '0; wline = '0; last_rline = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hs", {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready}, 6'b0);
        check("rst_ack", {axi_ack, axi_err}, 2'b00);
        check("rst_rline", rline, '0);
        check("rst_addr", {aw_addr, ar_addr}, '0);
        reset = 1'b1;
        idle_cycle();

        // Directed zero-wait write of the reference line.
        do_write(32'h0000_1234, {32'hD, 32'hC, 32'hB, 32'hA}, 2'b00, 0, 0, 1'b0);
        idle_cycle();
        // Zero-wait read, then read with valid every other cycle.
        do_read($urandom, rand_line(), -1, -1, 0, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        do_read(32'h0000_8008, {32'h44, 32'h33, 32'h22, 32'h11}, -1, -1, 0, 1'b1, 1'b0, 1'b0);
        idle_cycle();
        // AW stalled for 5 cycles.
        do_write(32'hABCD_0010, rand_line(), 2'b00, 0, 5, 1'b0);
        idle_cycle();
        // Error reads chained back-to-back, then a clean one.
        do_read($urandom, rand_line(), 1, -1, 0, 1'b0, 1'b0, 1'b0);
        do_read($urandom, rand_line(), -1, 2, 0, 1'b0, 1'b0, 1'b0);
        do_read($urandom, rand_line(), -1, -1, 0, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        // SLVERR write, then EXOKAY write (no error), back-to-back.
        do_write($urandom, rand_line(), 2'b10, 0, 0, 1'b0);
        do_write($urandom, rand_line(), 2'b01, 0, 0, 1'b0);
        idle_cycle();
        // Simultaneous strobes: read wins.
        do_read($urandom, rand_line(), -1, -1, 0, 1'b0, 1'b1, 1'b0);
        idle_cycle();
        // AW held off until after all data beats would have gone.
        do_write($urandom, rand_line(), 2'b00, 0, BEATS + 3, 1'b0);
        idle_cycle();

        // Reset asserted mid write-data phase.
        start_write = 1'b1; req_addr = $urandom; wline = rand_line();
        @(negedge clk);
        start_write = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
        cyc = 0;
        while (!w_valid && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        check("rst_mid_wvalid", w_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_mid_hs", {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready}, 6'b0);
        check("rst_mid_ack", {axi_ack, axi_err}, 2'b00);
        check("rst_mid_addr", {aw_addr, ar_addr}, '0);
        clear_drives();
        last_rline = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) idle_cycle();
        do_read($urandom, rand_line(), -1, -1, 0, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // Randomized traffic with stalls, errors and ignored strobes.
        for (int t = 0; t < 40; t++) begin
            st = $urandom_range(40);
            if ($urandom_range(1) == 1) begin
                do_write($urandom, rand_line(), 2'($urandom_range(3)), st, $urandom_range(3), 1'b1);
            end else begin
                rb = ($urandom_range(3) == 0) ? int'($urandom_range(BEATS - 1)) : -1;
                lb = ($urandom_range(3) == 0) ? int'($urandom_range(BEATS - 1)) : -1;
                do_read($urandom, rand_line(), rb, lb, st, 1'b0, 1'b0, 1'b1);
            end
            if ($urandom_range(1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4_burst_controller.md
# axi4_burst_controller

Parametrised AXI4 master-side handshake sequencer for the direct-mapped cache's refill/write-back path. It moves one whole cache line per request as a single INCR burst of `BEATS` beats, in either direction. It owns the address, data and last-beat signalling, and reports slave error responses. It sits between the cache controller FSM and the memory-side AXI4 interconnect.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, AXI data width; power of two, at least 8
- `BEATS`, 4, beats per line; power of two, 1..256

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start_read` / `start_write`  in  1  request strobes; sampled only in IDLE
- `req_addr`  in  ADDR_W  line address
- `wline`  in  BEATS*DATA_W  write-back line; beat 0 is at the LSBs
- `rline`  out  BEATS*DATA_W  refill line
- `axi_ack`  out  1  one-cycle completion pulse
- `axi_err`  out  1  error flag, valid only with `axi_ack`
- `aw_valid` out, `aw_ready` in, `aw_addr` out ADDR_W, `aw_len` out 8
- `w_valid` out, `w_ready` in, `w_data` out DATA_W, `w_last` out
- `b_valid` in, `b_ready` out, `b_resp` in 2
- `ar_valid` out, `ar_ready` in, `ar_addr` out ADDR_W, `ar_len` out 8
- `r_valid` in, `r_ready` out, `r_data` in DATA_W, `r_resp` in 2, `r_last` in

## Operation
- States: IDLE, WADDR, WDATA, BRESP, RADDR, RDATA.
- In IDLE, `start_read` has priority over `start_write`. The accepted request latches `req_addr` and (for writes) `wline`.
- Start strobes outside IDLE are ignored.
- Address outputs carry the latched address with the low log2(BEATS*DATA_W/8) bits cleared.
- `aw_len` = `ar_len` = BEATS-1. AxSIZE = log2(DATA_W/8) and AxBURST = INCR are tied off by the wrapper.
- Transitions:
  - IDLE→WADDR on accepted write.
  - WADDR→WDATA on `aw_valid && aw_ready`.
  - WDATA→BRESP on the handshake of the last beat.
  - BRESP→IDLE on `b_valid && b_ready`.
  - IDLE→RADDR on accepted read.
  - RADDR→RDATA on `ar_valid && ar_ready`.
  - RDATA→IDLE on the handshake of the last beat.
- `aw_valid`/`ar_valid` are high for the whole of WADDR/RADDR. They never drop before the handshake completes (AXI stability rule).
- Write data path:
  - Beat counter `cnt` (log2(BEATS) bits, minimum 1) clears on state entry and advances on each W or R handshake.
  - `w_valid` is high throughout WDATA; `w_data` = `wline` beat `cnt`; `w_last` = (`cnt` == BEATS-1).
  - `b_ready` is high only in BRESP.
- Read data path:
  - `r_ready` is high only in RDATA.
  - Each R handshake writes `r_data` into `rline` beat `cnt`.
- Error conditions; each sets the sticky `err` flag:
  - `b_resp` or `r_resp` in {SLVERR 2'b10, DECERR 2'b11}.
  - `r_last` mismatch: high before beat BEATS-1, or low on beat BEATS-1.
- The read always terminates after exactly BEATS beats, regardless of `r_last`.
- Completion: one cycle after the final B or R handshake, `axi_ack` = 1 and `axi_err` = `err` for one cycle. `err` clears in that same cycle.
- `rline` stays stable from the `axi_ack` cycle until the next read's first beat.

## Timing
- Reset values: all valid/ready outputs 0, `axi_ack` 0, `axi_err` 0, `rline` 0, `aw_addr`/`ar_addr` 0, `w_last` 0, state IDLE, `cnt` 0.
- Reset is asynchronous: asserting it mid-burst abandons the transaction immediately, with no ack.
- Zero-wait slave, write: start at cycle 0; `aw_valid` at cycle 1; W beats at cycles 2..BEATS+1; B handshake at cycle t; `axi_ack` at t+1.
- Zero-wait slave, read: start at cycle 0; AR at cycle 1; R beats at cycles 2..BEATS+1; `axi_ack` at BEATS+2.
- FSM is already in IDLE during the `axi_ack` cycle, so a start strobe in that cycle is accepted back-to-back.
- Slave stalls (ready/valid low) hold the state, `cnt` and all outputs unchanged.
- BEATS=1: `w_last` is high on the single beat; the `cnt` wrap is a no-op.

## Configuration
- `AXI4_BURST_OVERLAP_EN` defined: a write enters WADDR with both `aw_valid` and `w_valid` high.
  - AW and W handshakes may complete in either order or in the same cycle.
  - Local `aw_done` / `w_done` flags hold the completed channel low.
  - BRESP is entered once both channels are complete.
  - Zero-wait write ack moves one cycle earlier.
- Undefined: strict AW-then-W ordering as described above.

## Test plan
- Write, BEATS=4, zero-wait slave: `req_addr`=0x1234, `wline`={0xD,0xC,0xB,0xA} → `aw_addr`=0x1230, `aw_len`=3, `w_data` 0xA,0xB,0xC,0xD with `w_last` on 0xD, `b_resp`=0 → `axi_ack` at cycle 7 with `axi_err`=0.
- Read with `r_valid` gaps (valid every other cycle): data 0x11..0x44 → `rline`={0x44,0x33,0x22,0x11}, one `axi_ack` pulse, `r_ready` low outside RDATA.
- `aw_ready` low for 5 cycles → `aw_valid` held high for 6 cycles, no `w_valid` (non-overlap build).
- `r_resp`=SLVERR on beat 1, or `r_last` on beat 2 → all 4 beats still consumed, `axi_ack` with `axi_err`=1; next clean read gives `axi_err`=0.
- `start_read` and `start_write` together → read performed, write ignored; `reset` pulsed during WDATA → outputs 0 at once, no ack, FSM in IDLE.
- Overlap build, with `aw_ready` held low until after all W beats → BRESP entered only after the AW handshake; exactly one `axi_ack`.
